// File: rtl/regression_sequencer_pkg.sv
// Shared types and defaults for the regression sequencer.
// Holds the sequencer state encoding and the default run sizes.
package regression_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_SSTART,
        S_SWAIT,
        S_FIN
    } rs_state_t;

    localparam int RS_SAMPLES = 150;
    localparam int RS_STAGES  = 3;
    localparam int RS_ADDR_W  = 8;

    // Stage index width, never narrower than one bit.
    function automatic int stg_w(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

endpackage

// File: rtl/regression_sequencer_if.sv
// Sample-load and stage-control bus of the regression sequencer.
// master = sequencer side, slave = source/datapath side.
interface regression_sequencer_if #(
    parameter int ADDR_W = regression_pkg::RS_ADDR_W,
    parameter int STAGES = regression_pkg::RS_STAGES
);
    localparam int STG_W = regression_pkg::stg_w(STAGES);

    logic              in_valid;
    logic              in_ready;
    logic              write_en;
    logic [ADDR_W-1:0] addr;
    logic [STAGES-1:0] stage_done;
    logic [STAGES-1:0] stage_start;
    logic [STG_W-1:0]  stage_idx;

    modport master (
        input  in_valid,
        input  stage_done,
        output in_ready,
        output write_en,
        output addr,
        output stage_start,
        output stage_idx
    );

    modport slave (
        output in_valid,
        output stage_done,
        input  in_ready,
        input  write_en,
        input  addr,
        input  stage_start,
        input  stage_idx
    );

endinterface

// File: rtl/regression_sequencer_addr_counter.sv
// Sample write-address counter with terminal-count flag.
// Saturates at the terminal value instead of wrapping.
module rs_addr_counter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_last,
    output logic [ADDR_W-1:0] o_q,
    output logic              o_tc
);

    logic [ADDR_W-1:0] r_q;

    assign o_q  = r_q;
    assign o_tc = (r_q == i_last);

    // Count accepted samples, hold once the last address is reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en && !o_tc) begin
            r_q <= r_q + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/regression_sequencer.sv
// Top-level sequencer: loads SAMPLES pairs, then runs STAGES
// compute stages in order; abort returns to IDLE from anywhere.
module regression_sequencer
    import regression_pkg::*;
#(
    parameter int SAMPLES = RS_SAMPLES,
    parameter int ADDR_W  = RS_ADDR_W,
    parameter int STAGES  = RS_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_abort,
    regression_sequencer_if.master bus,
    output logic o_ready,
    output logic o_busy,
    output logic o_done
);

    localparam int STG_W = stg_w(STAGES);
    localparam logic [STG_W-1:0]  LAST_STG  = STG_W'(STAGES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SAMPLES - 1);

    rs_state_t         r_state;
    rs_state_t         w_next;
    logic [STG_W-1:0]  r_stage_idx;
    logic [STG_W-1:0]  w_idx_next;
    logic              r_in_ready;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic [STAGES-1:0] r_stage_start;
    logic              w_write_en;
    logic              w_clr;
    logic              w_tc;
    logic              w_stage_hit;
    logic [ADDR_W-1:0] w_addr;

    assign w_write_en  = bus.in_valid & r_in_ready & ~i_abort;
    assign w_clr       = i_abort | (r_state == S_INIT);
    assign w_stage_hit = bus.stage_done[r_stage_idx];

    rs_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_en   (w_write_en),
        .i_last (LAST_ADDR),
        .o_q    (w_addr),
        .o_tc   (w_tc)
    );

    // Next state and next stage index; abort overrides everything.
    always_comb begin
        w_next     = r_state;
        w_idx_next = r_stage_idx;
        if (i_abort) begin
            w_next     = S_IDLE;
            w_idx_next = '0;
        end else begin
            unique case (r_state)
                S_IDLE:   if (i_start) w_next = S_INIT;
                S_INIT: begin
                    w_next     = S_LOAD;
                    w_idx_next = '0;
                end
                S_LOAD:   if (w_write_en && w_tc) w_next = S_SSTART;
                S_SSTART: w_next = S_SWAIT;
                S_SWAIT: begin
                    if (w_stage_hit) begin
                        if (r_stage_idx == LAST_STG) begin
                            w_next = S_FIN;
                        end else begin
                            w_next     = S_SSTART;
                            w_idx_next = r_stage_idx + STG_W'(1);
                        end
                    end
                end
                S_FIN:    w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // State, stage index and outputs decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_stage_idx   <= '0;
            r_ready       <= 1'b1;
            r_busy        <= 1'b0;
            r_in_ready    <= 1'b0;
            r_done        <= 1'b0;
            r_stage_start <= '0;
        end else begin
            r_state       <= w_next;
            r_stage_idx   <= w_idx_next;
            r_ready       <= (w_next == S_IDLE);
            r_busy        <= (w_next != S_IDLE);
            r_in_ready    <= (w_next == S_LOAD);
            r_done        <= (w_next == S_FIN);
            r_stage_start <= (w_next == S_SSTART)
                           ? (STAGES'(1) << w_idx_next) : '0;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.write_en    = w_write_en;
    assign bus.addr        = w_addr;
    assign bus.stage_start = r_stage_start;
    assign bus.stage_idx   = r_stage_idx;
    assign o_ready         = r_ready;
    assign o_busy          = r_busy;
    assign o_done          = r_done;

endmodule
